// File: rtl/time_edit_controller_if.sv
// Button/handshake bundle between the debouncers, the RTC write path and the
// time edit controller.
//   btn_prog/left/right/up/down : debounced button levels (towards controller)
//   wr_ack                      : RTC writer accepted the commit
//   en_count                    : selected field, 0 = none, 1..6 = sec..year
//   enUP / enDOWN               : one-cycle step pulses for the field counters
//   prog_mode                   : programming-mode flag for the display
//   wr_req                      : commit request, held until acknowledged
interface time_edit_controller_if;
  logic       btn_prog;
  logic       btn_left;
  logic       btn_right;
  logic       btn_up;
  logic       btn_down;
  logic       wr_ack;
  logic [3:0] en_count;
  logic       enUP;
  logic       enDOWN;
  logic       prog_mode;
  logic       wr_req;

  // Driver side: buttons and acknowledge out, controller outputs in.
  modport master (
    output btn_prog, btn_left, btn_right, btn_up, btn_down, wr_ack,
    input  en_count, enUP, enDOWN, prog_mode, wr_req
  );

  // Controller side.
  modport slave (
    input  btn_prog, btn_left, btn_right, btn_up, btn_down, wr_ack,
    output en_count, enUP, enDOWN, prog_mode, wr_req
  );
endinterface

// File: rtl/time_edit_controller.sv
// Time/date edit sequencer. Turns debounced button levels into field
// selection, single-cycle step pulses with hold-to-repeat, and a commit
// request toward the RTC writer. Owns the programming-mode flag.
//   clk   : system clock
//   reset : asynchronous, active-low reset
//   bus   : time_edit_controller_if.slave (buttons, wr_ack in; en_count,
//           enUP, enDOWN, prog_mode, wr_req out; all outputs registered)
module time_edit_controller #(
  parameter int HOLD_DELAY     = 50_000_000,
  parameter int REPEAT_PERIOD  = 25_000_000,
  parameter int TIMEOUT_CYCLES = 1_000_000_000
) (
  input  logic                   clk,
  input  logic                   reset,
  time_edit_controller_if.slave  bus
);

  localparam int RW = $clog2(HOLD_DELAY + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EDIT   = 2'd1,
    COMMIT = 2'd2
  } state_t;

  typedef struct packed {
    logic          pulse;
    logic [RW-1:0] cnt;
  } step_t;

  state_t        state_q, state_d;
  logic          prev_prog, prev_left, prev_right, prev_up, prev_down;
  logic          rise_prog, rise_left, rise_right, rise_up, rise_down;
  logic [2:0]    field_q, field_d;
  logic [RW-1:0] up_cnt_q, up_cnt_d, dn_cnt_q, dn_cnt_d;
  logic [TW-1:0] idle_cnt_q, idle_cnt_d;
  logic          activity, timeout_hit;
  step_t         up_step, dn_step;
  logic [3:0]    en_count_d;
  logic          up_pulse_d, dn_pulse_d, prog_mode_d, wr_req_d;

  assign rise_prog  = bus.btn_prog  & ~prev_prog;
  assign rise_left  = bus.btn_left  & ~prev_left;
  assign rise_right = bus.btn_right & ~prev_right;
  assign rise_up    = bus.btn_up    & ~prev_up;
  assign rise_down  = bus.btn_down  & ~prev_down;

  // A held step button counts as activity so auto-repeat never times out.
  assign activity    = rise_prog | rise_left | rise_right | rise_up | rise_down |
                       bus.btn_up | bus.btn_down;
  assign timeout_hit = ~activity && (idle_cnt_q == TW'(TIMEOUT_CYCLES - 1));

  // Repeat counter for one step button. The first pulse comes from the rise;
  // after that the count restarts at HOLD_DELAY-REPEAT_PERIOD so each later
  // pulse is REPEAT_PERIOD apart. Not solo (released or both held) = idle.
  function automatic step_t step_next(input logic          solo,
                                      input logic          rise,
                                      input logic [RW-1:0] cnt);
    step_t s;
    s.pulse = 1'b0;
    s.cnt   = '0;
    if (solo) begin
      if (rise) begin
        s.pulse = 1'b1;
      end else if (cnt == RW'(HOLD_DELAY - 1)) begin
        s.pulse = 1'b1;
        s.cnt   = RW'(HOLD_DELAY - REPEAT_PERIOD);
      end else begin
        s.cnt = cnt + RW'(1);
      end
    end
    return s;
  endfunction

  // State register.
  // NOTE: sequential state is written with non-blocking assignments so every
  // flop samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic.
  // NOTE: every variable written in always_comb gets a default first, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (rise_prog) state_d = EDIT;
      EDIT: begin
        if (rise_prog)        state_d = COMMIT;
        else if (timeout_hit) state_d = IDLE;
      end
      COMMIT:  if (bus.wr_ack) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output / datapath next values. A commit rise wins over select and step.
  always_comb begin
    field_d    = field_q;
    up_cnt_d   = '0;
    dn_cnt_d   = '0;
    idle_cnt_d = '0;
    up_pulse_d = 1'b0;
    dn_pulse_d = 1'b0;
    up_step    = '0;
    dn_step    = '0;
    unique case (state_q)
      IDLE: if (rise_prog) field_d = 3'd1;
      EDIT: begin
        if (!rise_prog) begin
          if (rise_right && !rise_left)
            field_d = (field_q == 3'd6) ? 3'd1 : field_q + 3'd1;
          else if (rise_left && !rise_right)
            field_d = (field_q == 3'd1) ? 3'd6 : field_q - 3'd1;

          if (!activity && !timeout_hit) idle_cnt_d = idle_cnt_q + TW'(1);

          up_step    = step_next(bus.btn_up & ~bus.btn_down, rise_up, up_cnt_q);
          dn_step    = step_next(bus.btn_down & ~bus.btn_up, rise_down, dn_cnt_q);
          up_cnt_d   = up_step.cnt;
          dn_cnt_d   = dn_step.cnt;
          up_pulse_d = up_step.pulse;
          dn_pulse_d = dn_step.pulse;
        end
      end
      default: ;
    endcase
    en_count_d  = (state_d == EDIT) ? {1'b0, field_d} : 4'd0;
    prog_mode_d = (state_d != IDLE);
    wr_req_d    = (state_d == COMMIT);
  end

  // Datapath and registered outputs. The async reset clears wr_req at once,
  // even in the middle of a handshake.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prev_prog     <= 1'b0;
      prev_left     <= 1'b0;
      prev_right    <= 1'b0;
      prev_up       <= 1'b0;
      prev_down     <= 1'b0;
      field_q       <= 3'd1;
      up_cnt_q      <= '0;
      dn_cnt_q      <= '0;
      idle_cnt_q    <= '0;
      bus.en_count  <= 4'd0;
      bus.enUP      <= 1'b0;
      bus.enDOWN    <= 1'b0;
      bus.prog_mode <= 1'b0;
      bus.wr_req    <= 1'b0;
    end else begin
      prev_prog     <= bus.btn_prog;
      prev_left     <= bus.btn_left;
      prev_right    <= bus.btn_right;
      prev_up       <= bus.btn_up;
      prev_down     <= bus.btn_down;
      field_q       <= field_d;
      up_cnt_q      <= up_cnt_d;
      dn_cnt_q      <= dn_cnt_d;
      idle_cnt_q    <= idle_cnt_d;
      bus.en_count  <= en_count_d;
      bus.enUP      <= up_pulse_d;
      bus.enDOWN    <= dn_pulse_d;
      bus.prog_mode <= prog_mode_d;
      bus.wr_req    <= wr_req_d;
    end
  end

endmodule

// File: tb/tb_time_edit_controller.sv
// Self-checking bench for time_edit_controller: directed scenarios with
// hand-computed expectations plus a randomized phase, all compared every
// cycle against a behavioural model of the editing rules.
module tb_time_edit_controller;

  localparam int H = 10;
  localparam int R = 4;
  localparam int T = 100;

  localparam int M_IDLE   = 0;
  localparam int M_EDIT   = 1;
  localparam int M_COMMIT = 2;

  logic clk = 1'b0;
  logic reset;
  time_edit_controller_if bus();

  time_edit_controller #(
    .HOLD_DELAY    (H),
    .REPEAT_PERIOD (R),
    .TIMEOUT_CYCLES(T)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model state: mode, field, hold age of each step button (edges since its
  // rise while held alone), edge number of last activity in EDIT.
  int m_mode, m_field, m_up_age, m_dn_age, m_last_act, m_edge;
  bit m_prev[5];
  int exp_en, exp_up, exp_dn, exp_prog, exp_wr;

  int hits[$];
  int exp_hits[4] = '{0, 10, 14, 18};
  int wr_cnt, pulse_cnt, en_sum, wr_seen;

  task automatic check(input string name, input int actual, input int required);
    checks++;
    if (actual != required) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, actual, required, $time);
    end
  endtask

  function automatic bit repeat_fires(input int age);
    return (age == 0) || (age >= H && ((age - H) % R) == 0);
  endfunction

  task automatic model_reset();
    m_mode = M_IDLE;
    m_field = 1;
    m_up_age = 0;
    m_dn_age = 0;
    m_last_act = 0;
    for (int i = 0; i < 5; i++) m_prev[i] = 1'b0;
    exp_en = 0; exp_up = 0; exp_dn = 0; exp_prog = 0; exp_wr = 0;
  endtask

  // One clock edge of the editing rules, evaluated on the sampled inputs.
  task automatic model_edge();
    bit b[5];
    bit r[5];
    bit any_rise;
    bit up_only, dn_only;
    if (!reset) begin
      model_reset();
      return;
    end
    m_edge++;
    b[0] = bus.btn_prog; b[1] = bus.btn_left; b[2] = bus.btn_right;
    b[3] = bus.btn_up;   b[4] = bus.btn_down;
    any_rise = 1'b0;
    for (int i = 0; i < 5; i++) begin
      r[i] = b[i] && !m_prev[i];
      any_rise = any_rise | r[i];
    end
    up_only = b[3] && !b[4];
    dn_only = b[4] && !b[3];
    exp_up = 0;
    exp_dn = 0;
    case (m_mode)
      M_IDLE: if (r[0]) begin
        m_mode = M_EDIT;
        m_field = 1;
        m_last_act = m_edge;
      end
      M_EDIT: begin
        if (r[0]) begin
          m_mode = M_COMMIT;
        end else begin
          if (any_rise || b[3] || b[4]) m_last_act = m_edge;
          else if (m_edge - m_last_act == T) m_mode = M_IDLE;
          if (r[2] && !r[1])      m_field = m_field % 6 + 1;
          else if (r[1] && !r[2]) m_field = (m_field + 4) % 6 + 1;
          if (up_only) begin
            if (r[3]) m_up_age = 0; else m_up_age++;
            exp_up = repeat_fires(m_up_age);
          end else m_up_age = 0;
          if (dn_only) begin
            if (r[4]) m_dn_age = 0; else m_dn_age++;
            exp_dn = repeat_fires(m_dn_age);
          end else m_dn_age = 0;
        end
      end
      default: if (bus.wr_ack) m_mode = M_IDLE;
    endcase
    if (m_mode != M_EDIT) begin
      m_up_age = 0;
      m_dn_age = 0;
    end
    exp_en   = (m_mode == M_EDIT) ? m_field : 0;
    exp_prog = (m_mode != M_IDLE);
    exp_wr   = (m_mode == M_COMMIT);
    for (int i = 0; i < 5; i++) m_prev[i] = b[i];
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    check("en_count", bus.en_count, exp_en);
    check("enUP", bus.enUP, exp_up);
    check("enDOWN", bus.enDOWN, exp_dn);
    check("prog_mode", bus.prog_mode, exp_prog);
    check("wr_req", bus.wr_req, exp_wr);
  end

  // One cycle: edge, model update, then settle to just after the falling edge.
  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    #1;
  endtask

  task automatic release_all();
    bus.btn_prog = 0; bus.btn_left = 0; bus.btn_right = 0;
    bus.btn_up = 0; bus.btn_down = 0; bus.wr_ack = 0;
  endtask

  initial begin
    reset = 1'b0;
    release_all();
    m_edge = 0;
    model_reset();
    repeat (3) tick();
    check("rst_en_count", bus.en_count, 0);
    check("rst_prog_mode", bus.prog_mode, 0);
    check("rst_wr_req", bus.wr_req, 0);
    check("rst_steps", bus.enUP | bus.enDOWN, 0);
    reset = 1'b1;
    tick();

    // Mode entry.
    bus.btn_prog = 1; tick();
    check("entry_prog_mode", bus.prog_mode, 1);
    check("entry_field", bus.en_count, 1);
    bus.btn_prog = 0; tick();

    // Field selection with wrap and simultaneous left/right.
    bus.btn_left = 1; tick();
    check("left_wrap", bus.en_count, 6);
    bus.btn_left = 0; tick();
    bus.btn_right = 1; tick(); bus.btn_right = 0; tick();
    bus.btn_right = 1; tick(); bus.btn_right = 0; tick();
    check("right_twice", bus.en_count, 2);
    bus.btn_left = 1; bus.btn_right = 1; tick();
    check("left_right_same", bus.en_count, 2);
    bus.btn_left = 0; bus.btn_right = 0; tick();

    // Hold-to-repeat: pulses at relative edges 0, 10, 14, 18 only.
    hits.delete();
    bus.btn_up = 1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.enUP) hits.push_back(i);
    end
    bus.btn_up = 0;
    for (int i = 20; i < 30; i++) begin
      tick();
      if (bus.enUP) hits.push_back(i);
    end
    check("up_pulse_count", hits.size(), 4);
    for (int k = 0; k < 4; k++)
      check("up_pulse_edge", (k < hits.size()) ? hits[k] : -1, exp_hits[k]);

    // Both step buttons held: no pulses.
    pulse_cnt = 0;
    bus.btn_up = 1; bus.btn_down = 1;
    for (int i = 0; i < 30; i++) begin
      tick();
      pulse_cnt += bus.enUP + bus.enDOWN;
    end
    bus.btn_up = 0; bus.btn_down = 0; tick();
    check("both_held_pulses", pulse_cnt, 0);

    // Commit with delayed acknowledge; buttons during COMMIT have no effect.
    bus.btn_prog = 1; tick();
    wr_cnt = bus.wr_req;
    pulse_cnt = 0;
    en_sum = 0;
    bus.btn_prog = 0;
    for (int i = 1; i <= 5; i++) begin
      if (i == 2) begin bus.btn_left = 1; bus.btn_up = 1; bus.btn_prog = 1; end
      if (i == 4) release_all();
      tick();
      wr_cnt += bus.wr_req;
      pulse_cnt += bus.enUP + bus.enDOWN;
      en_sum += bus.en_count;
    end
    bus.wr_ack = 1; tick();
    wr_cnt += bus.wr_req;
    bus.wr_ack = 0;
    check("commit_wr_req_len", wr_cnt, 6);
    check("commit_pulses", pulse_cnt, 0);
    check("commit_en_count", en_sum, 0);
    check("commit_done_prog", bus.prog_mode, 0);
    check("commit_done_en", bus.en_count, 0);
    tick();

    // Inactivity timeout after 100 idle cycles, no write.
    wr_seen = 0;
    bus.btn_prog = 1; tick();
    bus.btn_prog = 0;
    for (int i = 0; i < 99; i++) begin
      tick();
      wr_seen += bus.wr_req;
    end
    check("timeout_not_yet", bus.prog_mode, 1);
    tick();
    wr_seen += bus.wr_req;
    check("timeout_prog_mode", bus.prog_mode, 0);
    check("timeout_en_count", bus.en_count, 0);
    check("timeout_no_write", wr_seen, 0);
    tick();

    // Asynchronous reset in the middle of the handshake.
    bus.btn_prog = 1; tick(); bus.btn_prog = 0; tick();
    bus.btn_prog = 1; tick(); bus.btn_prog = 0;
    check("pre_reset_wr_req", bus.wr_req, 1);
    reset = 1'b0;
    model_reset();
    #1;
    check("async_rst_wr_req", bus.wr_req, 0);
    check("async_rst_prog", bus.prog_mode, 0);
    check("async_rst_en", bus.en_count, 0);
    check("async_rst_steps", bus.enUP | bus.enDOWN, 0);
    tick(); tick();
    reset = 1'b1;
    tick();

    // Randomized phase against the model.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 19) == 0) bus.btn_prog  = ~bus.btn_prog;
      if ($urandom_range(0, 7)  == 0) bus.btn_left  = ~bus.btn_left;
      if ($urandom_range(0, 7)  == 0) bus.btn_right = ~bus.btn_right;
      if ($urandom_range(0, 15) == 0) bus.btn_up    = ~bus.btn_up;
      if ($urandom_range(0, 15) == 0) bus.btn_down  = ~bus.btn_down;
      bus.wr_ack = ($urandom_range(0, 3) == 0);
      reset = ($urandom_range(0, 599) != 0);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
